// File: rtl/sudoku_game_fsm.sv
// Sudoku game controller: title, level select, puzzle load, cursor map,
// digit entry and win/lose screens, driving a single-cell board write port.
module sudoku_game_fsm #(
  parameter  int unsigned BOX        = 3,
  parameter  int unsigned LEVELS     = 2,
  parameter  int unsigned MAX_ERRORS = 3,
  localparam int unsigned D          = BOX * BOX,
  localparam int unsigned CW         = $clog2(D * D + 1),
  localparam int unsigned VW         = $clog2(D + 1),
  localparam int unsigned XW         = $clog2(D),
  localparam int unsigned LW         = $clog2(LEVELS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_button,
  input  logic          a_button,
  input  logic          b_button,
  input  logic          up_button,
  input  logic          down_button,
  input  logic          left_button,
  input  logic          right_button,
  input  logic          load_done,
  input  logic [CW-1:0] load_empty_count,
  input  logic          cell_fixed,
  input  logic [VW-1:0] cell_value,
  input  logic [VW-1:0] cell_solution,
  output logic [2:0]    current_state,
  output logic [XW-1:0] cursor_x,
  output logic [XW-1:0] cursor_y,
  output logic [VW-1:0] digit,
  output logic [LW-1:0] level,
  output logic [3:0]    error_count,
  output logic [CW-1:0] empty_count,
  output logic          load_req,
  output logic          wr_en,
  output logic [XW-1:0] wr_x,
  output logic [XW-1:0] wr_y,
  output logic [VW-1:0] wr_data,
  output logic          title_display,
  output logic          difficulty_display,
  output logic          running_display
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_LOADING = 3'd2,
    S_MAP     = 3'd3,
    S_DIGIT   = 3'd4,
    S_WIN     = 3'd5,
    S_LOSE    = 3'd6
  } state_t;

  localparam logic [XW-1:0] X_LAST   = XW'(D - 1);
  localparam logic [LW-1:0] L_LAST   = LW'(LEVELS - 1);
  localparam logic [VW-1:0] V_MAX    = VW'(D);
  localparam logic [3:0]    ERR_LAST = 4'(MAX_ERRORS - 1);
  localparam logic [3:0]    ERR_MAX  = 4'(MAX_ERRORS);

  state_t state_q;

  assign current_state      = state_q;
  assign title_display      = (state_q == S_IDLE);
  assign difficulty_display = (state_q == S_SELECT);
  assign running_display    = (state_q == S_MAP) || (state_q == S_DIGIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cursor_x    <= '0;
      cursor_y    <= '0;
      digit       <= '0;
      level       <= '0;
      error_count <= '0;
      empty_count <= '0;
      load_req    <= 1'b0;
      wr_en       <= 1'b0;
      wr_x        <= '0;
      wr_y        <= '0;
      wr_data     <= '0;
    end else begin
      load_req <= 1'b0;
      wr_en    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_button) state_q <= S_SELECT;
        end
        S_SELECT: begin
          if (b_button) begin
            state_q <= S_IDLE;
          end else if (a_button) begin
            state_q  <= S_LOADING;
            load_req <= 1'b1;
          end else if (up_button) begin
            level <= (level == '0) ? L_LAST : level - LW'(1);
          end else if (down_button) begin
            level <= (level == L_LAST) ? '0 : level + LW'(1);
          end
        end
        S_LOADING: begin
          if (load_done) begin
            empty_count <= load_empty_count;
            error_count <= '0;
            cursor_x    <= '0;
            cursor_y    <= '0;
            state_q     <= (load_empty_count == '0) ? S_WIN : S_MAP;
          end
        end
        S_MAP: begin
          // start abandons, then a (only on an open cell), then one arrow
          if (start_button) begin
            state_q <= S_SELECT;
          end else if (a_button) begin
            if (!cell_fixed && cell_value == '0) begin
              state_q <= S_DIGIT;
              digit   <= VW'(1);
            end
          end else if (up_button) begin
            cursor_y <= (cursor_y == '0) ? X_LAST : cursor_y - XW'(1);
          end else if (down_button) begin
            cursor_y <= (cursor_y == X_LAST) ? '0 : cursor_y + XW'(1);
          end else if (left_button) begin
            cursor_x <= (cursor_x == '0) ? X_LAST : cursor_x - XW'(1);
          end else if (right_button) begin
            cursor_x <= (cursor_x == X_LAST) ? '0 : cursor_x + XW'(1);
          end
        end
        S_DIGIT: begin
          if (b_button) begin
            state_q <= S_MAP;
          end else if (a_button) begin
            if (digit == cell_solution) begin
              wr_en   <= 1'b1;
              wr_x    <= cursor_x;
              wr_y    <= cursor_y;
              wr_data <= digit;
              if (empty_count != '0) empty_count <= empty_count - CW'(1);
              state_q <= (empty_count <= CW'(1)) ? S_WIN : S_MAP;
            end else begin
              if (error_count < ERR_MAX) error_count <= error_count + 4'd1;
              state_q <= (error_count >= ERR_LAST) ? S_LOSE : S_MAP;
            end
          end else if (up_button) begin
            digit <= (digit >= V_MAX) ? VW'(1) : digit + VW'(1);
          end else if (down_button) begin
            digit <= (digit <= VW'(1)) ? V_MAX : digit - VW'(1);
          end
        end
        S_WIN, S_LOSE: begin
          if (start_button) state_q <= S_SELECT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_game_fsm.sv
// Directed bench for sudoku_game_fsm (BOX=3, LEVELS=2, MAX_ERRORS=3).
module tb_sudoku_game_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_button, a_button, b_button, up_button, down_button;
  logic       left_button, right_button, load_done;
  logic [6:0] load_empty_count;
  logic       cell_fixed;
  logic [3:0] cell_value, cell_solution;
  logic [2:0] current_state;
  logic [3:0] cursor_x, cursor_y, digit, error_count, wr_x, wr_y, wr_data;
  logic [0:0] level;
  logic [6:0] empty_count;
  logic       load_req, wr_en, title_display, difficulty_display, running_display;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int IDLE = 0, SEL = 1, LOAD = 2, MAP = 3, DIG = 4, WIN = 5, LOSE = 6;

  sudoku_game_fsm #(.BOX(3), .LEVELS(2), .MAX_ERRORS(3)) dut (
    .clk(clk), .reset(reset),
    .start_button(start_button), .a_button(a_button), .b_button(b_button),
    .up_button(up_button), .down_button(down_button),
    .left_button(left_button), .right_button(right_button),
    .load_done(load_done), .load_empty_count(load_empty_count),
    .cell_fixed(cell_fixed), .cell_value(cell_value), .cell_solution(cell_solution),
    .current_state(current_state), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .digit(digit), .level(level), .error_count(error_count), .empty_count(empty_count),
    .load_req(load_req), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .title_display(title_display), .difficulty_display(difficulty_display),
    .running_display(running_display)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    start_button = 0; a_button = 0; b_button = 0; up_button = 0; down_button = 0;
    left_button = 0; right_button = 0; load_done = 0;
  endtask

  // one clock edge with the currently driven inputs, then sample 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic load_puzzle(input logic [6:0] cnt);
    load_empty_count = cnt;
    load_done = 1; step();
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    load_empty_count = '0;
    cell_fixed = 0; cell_value = 0; cell_solution = 5;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", current_state, IDLE);
    check_eq("rst_title", title_display, 1);
    check_eq("rst_cursor", {cursor_x, cursor_y}, 0);
    check_eq("rst_outs", {digit, level, error_count, empty_count, load_req, wr_en}, 0);
    reset = 1;
    a_button = 1; step();
    check_eq("idle_ignores_a", current_state, IDLE);

    // start, down, a -> LOADING with level 1
    start_button = 1; step();
    check_eq("select_state", current_state, SEL);
    check_eq("select_flag", difficulty_display, 1);
    down_button = 1; step();
    check_eq("level_down", level, 1);
    a_button = 1; step();
    check_eq("loading_state", current_state, LOAD);
    check_eq("load_req_hi", load_req, 1);
    step();
    check_eq("load_req_lo", load_req, 0);
    check_eq("level_stable", level, 1);
    load_puzzle(7'd2);
    check_eq("map_state", current_state, MAP);
    check_eq("map_running", running_display, 1);
    check_eq("map_empty", empty_count, 2);
    check_eq("map_cursor", {cursor_x, cursor_y}, 0);

    // cursor wrap and arrow priority
    up_button = 1; step();
    check_eq("up_wrap", {cursor_x, cursor_y}, {4'd0, 4'd8});
    left_button = 1; step();
    check_eq("left_wrap", {cursor_x, cursor_y}, {4'd8, 4'd8});
    up_button = 1; right_button = 1; step();
    check_eq("up_beats_right", {cursor_x, cursor_y}, {4'd8, 4'd7});

    // correct entry of 5
    a_button = 1; step();
    check_eq("digit_state", current_state, DIG);
    check_eq("digit_init", digit, 1);
    left_button = 1; step();
    check_eq("digit_left_ignored", digit, 1);
    for (int i = 0; i < 4; i++) begin
      up_button = 1; step();
    end
    check_eq("digit_up4", digit, 5);
    a_button = 1; step();
    check_eq("wr_en_hi", wr_en, 1);
    check_eq("wr_fields", {wr_x, wr_y, wr_data}, {4'd8, 4'd7, 4'd5});
    check_eq("empty_dec", empty_count, 1);
    check_eq("after_write", current_state, MAP);
    step();
    check_eq("wr_en_lo", wr_en, 0);

    cell_fixed = 1;
    a_button = 1; step();
    check_eq("fixed_ignored", current_state, MAP);
    cell_fixed = 0; cell_value = 3;
    a_button = 1; step();
    check_eq("filled_ignored", current_state, MAP);
    cell_value = 0;

    // digit wrap and a+b cancel
    a_button = 1; step();
    down_button = 1; step();
    check_eq("digit_down_wrap", digit, 9);
    up_button = 1; step();
    check_eq("digit_up_wrap", digit, 1);
    a_button = 1; b_button = 1; step();
    check_eq("ab_cancel_state", current_state, MAP);
    check_eq("ab_cancel_wr", wr_en, 0);
    check_eq("ab_cancel_err", error_count, 0);

    // three wrong confirms (digit 1 vs solution 5)
    for (int i = 1; i <= 3; i++) begin
      a_button = 1; step();
      a_button = 1; step();
      check_eq($sformatf("err_cnt_%0d", i), error_count, i);
      check_eq($sformatf("err_nowr_%0d", i), wr_en, 0);
      check_eq($sformatf("err_state_%0d", i), current_state, (i == 3) ? LOSE : MAP);
    end
    check_eq("lose_empty_hold", empty_count, 1);
    start_button = 1; step();
    check_eq("lose_to_select", current_state, SEL);
    check_eq("err_hold", error_count, 3);
    check_eq("cursor_hold", {cursor_x, cursor_y}, {4'd8, 4'd7});

    // level wraps, load one cell, finish with a win
    down_button = 1; step();
    check_eq("level_wrap_down", level, 0);
    up_button = 1; step();
    check_eq("level_wrap_up", level, 1);
    a_button = 1; step();
    load_puzzle(7'd1);
    check_eq("reload_err_clr", error_count, 0);
    check_eq("reload_cursor", {cursor_x, cursor_y}, 0);
    cell_solution = 1;
    a_button = 1; step();
    a_button = 1; step();
    check_eq("win_state", current_state, WIN);
    check_eq("win_wr", wr_en, 1);
    check_eq("win_empty", empty_count, 0);

    // empty puzzle goes straight to WIN
    start_button = 1; step();
    a_button = 1; step();
    load_puzzle(7'd0);
    check_eq("load_zero_win", current_state, WIN);

    // async reset in DIGIT
    start_button = 1; step();
    a_button = 1; step();
    load_puzzle(7'd3);
    a_button = 1; step();
    check_eq("pre_reset_digit", current_state, DIG);
    reset = 0;
    #2;
    check_eq("areset_state", current_state, IDLE);
    check_eq("areset_outs", {digit, level, error_count, empty_count, load_req, wr_en}, 0);
    check_eq("areset_wr", {wr_x, wr_y, wr_data, cursor_x, cursor_y}, 0);
    a_button = 1;
    step();
    reset = 1;
    step();
    check_eq("resume_idle", current_state, IDLE);
    check_eq("resume_no_wr", wr_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
